// File: rtl/sweep_ctrl.sv
// Sequencer that steers an external 8-bit up/down counter through triangular
// sweeps between latched bounds lo_q and hi_q, for a set number of sweeps or until stopped.
module sweep_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             zero,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [CW-1:0]    cycles,
   input  logic [WIDTH-1:0] ctr_count,
   output logic             ctr_ld,
   output logic             ctr_clr,
   output logic             ctr_mode,
   output logic [WIDTH-1:0] ctr_d,
   output logic             busy,
   output logic             dir_up,
   output logic             done,
   output logic             err,
   output logic [CW-1:0]    sweeps
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_UP   = 3'd2,
      S_DOWN = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CW_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CW_ZERO = {CW{1'b0}};

   state_t           state_r, state_s;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic [CW-1:0]    cyc_q;
   logic [CW-1:0]    sweeps_r;
   logic [CW-1:0]    sweeps_inc_s;
   logic             done_r, err_r;
   logic             start_ok_s, start_bad_s, sweep_end_s;

   assign sweeps_inc_s = sweeps_r + CW_ONE;

   // Next-state and counter control; hold (load own value) is the default.
   always_comb begin
      state_s     = state_r;
      ctr_ld      = 1'b1;
      ctr_d       = ctr_count;
      ctr_clr     = 1'b0;
      ctr_mode    = 1'b0;
      start_ok_s  = 1'b0;
      start_bad_s = 1'b0;
      sweep_end_s = 1'b0;
      if (!rst_n) begin
         state_s = S_IDLE;
      end else if (stop) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (zero) begin
                  ctr_ld  = 1'b0;
                  ctr_clr = 1'b1;
               end else begin
                  ctr_ld  = 1'b1;
               end
               if (start && (lo < hi)) begin
                  start_ok_s = 1'b1;
                  state_s    = S_LOAD;
               end else if (start) begin
                  start_bad_s = 1'b1;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_LOAD: begin
               ctr_d   = lo_q;
               state_s = S_UP;
            end
            S_UP: begin
               ctr_ld   = 1'b0;
               ctr_mode = 1'b1;
               if (ctr_count == (hi_q - W_ONE)) begin
                  state_s = S_DOWN;
               end else begin
                  state_s = S_UP;
               end
            end
            S_DOWN: begin
               ctr_ld = 1'b0;
               if (ctr_count == (lo_q + W_ONE)) begin
                  sweep_end_s = 1'b1;
                  if ((cyc_q != CW_ZERO) && (sweeps_inc_s == cyc_q)) begin
                     state_s = S_DONE;
                  end else begin
                     state_s = S_UP;
                  end
               end else begin
                  state_s = S_DOWN;
               end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Latched run parameters, sweep counter and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q     <= {WIDTH{1'b0}};
         hi_q     <= {WIDTH{1'b0}};
         cyc_q    <= CW_ZERO;
         sweeps_r <= CW_ZERO;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         done_r <= (state_s == S_DONE);
         err_r  <= start_bad_s;
         if (start_ok_s) begin
            lo_q     <= lo;
            hi_q     <= hi;
            cyc_q    <= cycles;
            sweeps_r <= CW_ZERO;
         end else if (sweep_end_s) begin
            sweeps_r <= sweeps_inc_s;
         end else begin
            sweeps_r <= sweeps_r;
         end
      end
   end

   assign busy   = (state_r != S_IDLE);
   assign dir_up = (state_r == S_UP);
   assign done   = done_r;
   assign err    = err_r;
   assign sweeps = sweeps_r;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: a behavioural counter closes the loop, and the expected
// trajectory comes from the triangular-wave formula for a run.
module tb_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, zero = 1'b0;
   logic [7:0] lo = 8'd0, hi = 8'd0, cycles = 8'd0;
   logic [7:0] ctr_count, ctr_d, sweeps;
   logic       ctr_ld, ctr_clr, ctr_mode, busy, dir_up, done, err;
   logic [7:0] cnt_model = 8'd0;
   int         n_checks = 0, n_errors = 0;
   int         exp_cnt = 0;

   sweep_ctrl #(.WIDTH(8), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .zero(zero),
      .lo(lo), .hi(hi), .cycles(cycles), .ctr_count(ctr_count),
      .ctr_ld(ctr_ld), .ctr_clr(ctr_clr), .ctr_mode(ctr_mode), .ctr_d(ctr_d),
      .busy(busy), .dir_up(dir_up), .done(done), .err(err), .sweeps(sweeps)
   );

   always #5 clk = ~clk;

   assign ctr_count = cnt_model;

   // Loadable up/down counter (ld > clr > mode), never reset.
   always @(posedge clk) begin
      if (ctr_ld) cnt_model <= ctr_d;
      else if (ctr_clr) cnt_model <= 8'd0;
      else if (ctr_mode) cnt_model <= cnt_model + 8'd1;
      else cnt_model <= cnt_model - 8'd1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Position k counting steps after the load in a lo..hi triangle wave.
   function automatic int tri_pos(input int l, input int h, input int k);
      int d, r;
      d = h - l;
      r = k % (2 * d);
      return (r <= d) ? l + r : l + 2 * d - r;
   endfunction

   task automatic launch(input int l, input int h, input int c);
      lo = l[7:0]; hi = h[7:0]; cycles = c[7:0]; start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("sweeps_cleared", sweeps, 0);
      tick();
      chk("load_value", ctr_count, l);
   endtask

   task automatic run_sweeps(input int l, input int h, input int c, input bit poke, input int idle_n);
      int p, total;
      p = 2 * (h - l);
      total = c * p;
      launch(l, h, c);
      for (int k = 1; k <= total; k++) begin
         if (poke && k == 2) begin
            start = 1'b0; lo = 8'd50; hi = 8'd60; cycles = 8'd9;
         end
         tick();
         if (poke && k == 1) begin
            start = 1'b1; lo = 8'd50; hi = 8'd60; cycles = 8'd9;
         end
         chk("count", ctr_count, tri_pos(l, h, k));
         chk("sweeps_run", sweeps, k / p);
         chk("done", done, (k == total) ? 1 : 0);
         if (k < total) chk("dir_up", dir_up, ((k % p) < (h - l)) ? 1 : 0);
      end
      chk("busy_in_done", busy, 1);
      tick();
      chk("busy_end", busy, 0);
      chk("done_end", done, 0);
      chk("sweeps_kept", sweeps, c % 256);
      for (int i = 0; i < idle_n; i++) tick();
      chk("idle_count", ctr_count, l);
      exp_cnt = l;
   endtask

   task automatic run_stop(input int l, input int h, input int m);
      int p;
      p = 2 * (h - l);
      launch(l, h, 0);
      for (int k = 1; k <= m; k++) tick();
      chk("pre_stop_count", ctr_count, tri_pos(l, h, m));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_count", ctr_count, tri_pos(l, h, m));
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_sweeps", sweeps, m / p);
      for (int i = 0; i < 4; i++) tick();
      chk("stop_hold", ctr_count, tri_pos(l, h, m));
      exp_cnt = tri_pos(l, h, m);
   endtask

   task automatic try_bad(input int l, input int h);
      lo = l[7:0]; hi = h[7:0]; cycles = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      tick();
      chk("err_clear", err, 0);
      chk("err_count", ctr_count, exp_cnt);
   endtask

   initial begin
      int l, h, c, m;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_ld_hold", ctr_ld, 1);
      chk("rst_sweeps", sweeps, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_count", ctr_count, 0);

      run_sweeps(3, 6, 2, 1'b0, 10);
      run_sweeps(254, 255, 3, 1'b0, 2);
      run_stop(10, 20, 16);
      try_bad(5, 5);
      try_bad(9, 4);

      zero = 1'b1;
      tick();
      zero = 1'b0;
      chk("zero_count", ctr_count, 0);
      exp_cnt = 0;

      run_sweeps(3, 6, 1, 1'b1, 2);

      // Async reset mid-UP at count 7, after one sweep has completed.
      launch(5, 8, 0);
      for (int k = 1; k <= 8; k++) tick();
      chk("pre_rst_sweeps", sweeps, 1);
      chk("pre_rst_dir", dir_up, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_sweeps", sweeps, 0);
      chk("arst_count", ctr_count, 7);
      tick();
      tick();
      chk("arst_hold", ctr_count, 7);
      rst_n = 1'b1;
      tick();
      chk("post_rst_count", ctr_count, 7);
      chk("post_rst_busy", busy, 0);
      exp_cnt = 7;

      lo = 8'd1; hi = 8'd9; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("ss_busy", busy, 0);
      chk("ss_err", err, 0);
      tick();
      chk("ss_count", ctr_count, exp_cnt);

      for (int it = 0; it < 6; it++) begin
         l = $urandom_range(0, 240);
         h = l + $urandom_range(1, 8);
         c = $urandom_range(1, 3);
         run_sweeps(l, h, c, 1'b0, 1);
         m = $urandom_range(0, 6 * (h - l) - 1);
         run_stop(l, h, m);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
- Sequencer for the loadable up/down counter (ld > clr > mode priority, no enable, 8-bit).
- Drives the counter's ld/clr/mode/d_in so it sweeps triangularly between programmed bounds lo and hi, for a programmed number of sweeps or indefinitely.
- Holds the counter frozen whenever no sweep is active.
- Sits between the register/host interface and one counter instance.

Parameters:
WIDTH, 8, counter data width (lo, hi, ctr_count, ctr_d)
CW, 8, width of the sweep-count fields (cycles, sweeps)

Ports:
clk  input  1  rising-edge clock, shared with the counter
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep run (sampled in IDLE only)
stop  input  1  abort the run; the counter freezes this same cycle
zero  input  1  clear the counter to 0 (IDLE only)
lo  input  WIDTH  lower bound, unsigned
hi  input  WIDTH  upper bound, unsigned
cycles  input  CW  sweeps to run; 0 = run until stop
ctr_count  input  WIDTH  counter output, fed back
ctr_ld  output  1  counter load
ctr_clr  output  1  counter clear
ctr_mode  output  1  counter direction, 1 = up
ctr_d  output  WIDTH  counter load data
busy  output  1  high in any state other than IDLE
dir_up  output  1  high in UP
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle registered pulse on rejected start
sweeps  output  CW  completed sweeps in the current or last run

Behaviour:
- State register uses async reset to IDLE. Registered outputs reset as follows: sweeps=0, done=0, err=0. lo_q, hi_q and cyc_q also reset to 0.
- Control outputs are combinational from state, stop, zero and ctr_count. The hold encoding is ctr_ld=1, ctr_d=ctr_count, ctr_clr=0, ctr_mode=0. Hold is driven during reset, IDLE (unless zero), DONE, and any cycle with stop=1.
- IDLE:
  - zero=1: ctr_ld=0, ctr_clr=1, so the counter reads 0 after the edge.
  - start=1 with lo<hi and stop=0: latch lo_q, hi_q, cyc_q; set sweeps=0; go to LOAD.
  - start=1 with lo>=hi: err pulses the next cycle; stay in IDLE.
  - start and stop together: stop wins and start is ignored.
- LOAD (1 cycle): ctr_ld=1, ctr_d=lo_q. Next state is UP.
- UP: ctr_ld=0, ctr_clr=0, ctr_mode=1. When ctr_count==hi_q-1, the next state is DOWN (the counter reaches hi_q on that same edge).
- DOWN: ctr_mode=0. When ctr_count==lo_q+1, the counter reaches lo_q and one sweep completes:
  - sweeps increments, wrapping mod 2^CW.
  - If cyc_q!=0 and sweeps+1==cyc_q, the next state is DONE; otherwise it is UP.
- DONE (1 cycle): hold; done=1. Next state is IDLE. sweeps keeps its value until the next accepted start.
- stop=1 in LOAD, UP or DOWN: controls hold in that cycle, so ctr_count is unchanged across the edge. Next state is IDLE, with no done pulse.
- start, lo, hi and cycles are ignored while busy. The latched values govern the run.
- One sweep is lo→hi→lo and takes 2*(hi_q-lo_q) counting cycles. A run of N sweeps occupies 1 + 2N(hi_q-lo_q) cycles plus the DONE cycle.
- Comparisons are unsigned. Because lo_q<hi_q, hi_q-1 and lo_q+1 never wrap, and the counter never leaves [lo_q, hi_q].
- Async reset mid-run: the controller returns to IDLE immediately and holds the counter at its current value. The counter contents are not cleared.

Test Plan:
- Reset, then lo=3, hi=6, cycles=2, pulse start: ctr_count after each edge from LOAD reads 3,4,5,6,5,4,3,4,5,6,5,4,3. done is high for 1 cycle after the final 3, sweeps=2, busy drops next cycle, and the count stays 3 for 10 further idle cycles.
- lo=254, hi=255, cycles=3: count reads 254,255,254,255,254,255,254, then done with sweeps=3. Edge bounds cause no wrap.
- lo=10, hi=20, cycles=0, stop asserted when ctr_count=14 in DOWN: count stays 14 indefinitely, no done pulse, busy=0 next cycle.
- lo=5, hi=5 start: err pulses 1 cycle, busy stays 0, count unchanged. Repeat with lo=9, hi=4: same result.
- zero pulse in IDLE with count=14: count becomes 0. start pulsed while busy with different lo/hi: ignored, and the run continues with the latched bounds.
- rst_n low mid-UP at count=7: busy=0, sweeps=0 immediately, count holds 7 through and after reset. start and stop asserted together in IDLE: stays in IDLE.
